// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding.
// Feeds srca/srcb/alucontrol to the ALU and store data/destination to EX/MEM.
module id_ex_operand_stage #(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           stall,
    input  logic           flush,
    input  logic           id_valid,
    input  logic [DW-1:0]  id_rd1,
    input  logic [DW-1:0]  id_rd2,
    input  logic [DW-1:0]  id_imm,
    input  logic [4:0]     id_shamt,
    input  logic [3:0]     id_alucontrol,
    input  logic           id_alusrc,
    input  logic           id_shiftsrc,
    input  logic           id_regwrite,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic [RAW-1:0] id_writereg,
    input  logic           mem_regwrite,
    input  logic [RAW-1:0] mem_writereg,
    input  logic [DW-1:0]  mem_aluout,
    input  logic           wb_regwrite,
    input  logic [RAW-1:0] wb_writereg,
    input  logic [DW-1:0]  wb_result,
    output logic [DW-1:0]  srca,
    output logic [DW-1:0]  srcb,
    output logic [3:0]     alucontrol,
    output logic [DW-1:0]  ex_wdata,
    output logic           ex_valid,
    output logic           ex_regwrite,
    output logic [RAW-1:0] ex_writereg,
    output logic [1:0]     fwd_a,
    output logic [1:0]     fwd_b
);

    typedef struct packed {
        logic           valid;
        logic           regwrite;
        logic [3:0]     alucontrol;
        logic           alusrc;
        logic           shiftsrc;
        logic [4:0]     shamt;
        logic [DW-1:0]  rd1;
        logic [DW-1:0]  rd2;
        logic [DW-1:0]  imm;
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
        logic [RAW-1:0] writereg;
    } id_ex_t;

    id_ex_t ex_q, ex_d;

    // The all-zero value is the bubble, so flush and reset share it.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d.valid      = id_valid;
            ex_d.regwrite   = id_regwrite & id_valid;
            ex_d.alucontrol = id_alucontrol;
            ex_d.alusrc     = id_alusrc;
            ex_d.shiftsrc   = id_shiftsrc;
            ex_d.shamt      = id_shamt;
            ex_d.rd1        = id_rd1;
            ex_d.rd2        = id_rd2;
            ex_d.imm        = id_imm;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.writereg   = id_writereg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    logic mem_a_hit, mem_b_hit, wb_a_hit, wb_b_hit;
    logic [DW-1:0] fwd_a_val, fwd_b_val;

    assign mem_a_hit = mem_regwrite && (mem_writereg != '0)
                    && (mem_writereg == ex_q.rs);
    assign mem_b_hit = mem_regwrite && (mem_writereg != '0)
                    && (mem_writereg == ex_q.rt);
    assign wb_a_hit  = wb_regwrite && (wb_writereg != '0)
                    && (wb_writereg == ex_q.rs);
    assign wb_b_hit  = wb_regwrite && (wb_writereg != '0)
                    && (wb_writereg == ex_q.rt);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_a     = 2'b00;
        fwd_a_val = ex_q.rd1;
        if (mem_a_hit) begin
            fwd_a     = 2'b10;
            fwd_a_val = mem_aluout;
        end else if (wb_a_hit) begin
            fwd_a     = 2'b01;
            fwd_a_val = wb_result;
        end
    end

    always_comb begin
        fwd_b     = 2'b00;
        fwd_b_val = ex_q.rd2;
        if (mem_b_hit) begin
            fwd_b     = 2'b10;
            fwd_b_val = mem_aluout;
        end else if (wb_b_hit) begin
            fwd_b     = 2'b01;
            fwd_b_val = wb_result;
        end
    end

    assign srca        = ex_q.shiftsrc ? {{(DW-5){1'b0}}, ex_q.shamt}
                                       : fwd_a_val;
    assign srcb        = ex_q.alusrc ? ex_q.imm : fwd_b_val;
    assign ex_wdata    = fwd_b_val;
    assign alucontrol  = ex_q.alucontrol;
    assign ex_valid    = ex_q.valid;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_writereg = ex_q.writereg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: random and directed stimulus
// against a behavioural pipeline-register and forwarding model.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alucontrol;
    logic        id_alusrc, id_shiftsrc, id_regwrite;
    logic [4:0]  id_rs, id_rt, id_writereg;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_writereg, wb_writereg;
    logic [31:0] mem_aluout, wb_result;
    logic [31:0] srca, srcb, ex_wdata;
    logic [3:0]  alucontrol;
    logic        ex_valid, ex_regwrite;
    logic [4:0]  ex_writereg;
    logic [1:0]  fwd_a, fwd_b;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alucontrol(id_alucontrol), .id_alusrc(id_alusrc),
        .id_shiftsrc(id_shiftsrc), .id_regwrite(id_regwrite),
        .id_rs(id_rs), .id_rt(id_rt), .id_writereg(id_writereg),
        .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg),
        .mem_aluout(mem_aluout), .wb_regwrite(wb_regwrite),
        .wb_writereg(wb_writereg), .wb_result(wb_result),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
        .ex_wdata(ex_wdata), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_writereg(ex_writereg),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [31:0] wdata;
        logic [3:0]  alu;
        logic        valid;
        logic        regwrite;
        logic [4:0]  wr;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } out_t;

    typedef struct {
        logic        valid, regwrite, alusrc, shiftsrc;
        logic [3:0]  alu;
        logic [4:0]  shamt, rs, rt, wr;
        logic [31:0] rd1, rd2, imm;
    } inst_t;

    inst_t m;
    out_t  exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic        p_mem_rw, p_wb_rw;
    logic [4:0]  p_mem_wr, p_wb_wr;
    logic [31:0] p_mem_val, p_wb_val;

    function automatic inst_t bubble();
        inst_t b;
        b.valid = 0; b.regwrite = 0; b.alusrc = 0; b.shiftsrc = 0;
        b.alu = 0; b.shamt = 0; b.rs = 0; b.rt = 0; b.wr = 0;
        b.rd1 = 0; b.rd2 = 0; b.imm = 0;
        return b;
    endfunction

    // Clock-edge behaviour of the ID/EX register, from the visible inputs.
    function automatic void model_edge();
        if (flush) m = bubble();
        else if (!stall) begin
            m.valid = id_valid;
            m.regwrite = id_regwrite && id_valid;
            m.alusrc = id_alusrc; m.shiftsrc = id_shiftsrc;
            m.alu = id_alucontrol; m.shamt = id_shamt;
            m.rs = id_rs; m.rt = id_rt; m.wr = id_writereg;
            m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm;
        end
    endfunction

    function automatic void resolve(input logic [4:0] r,
                                    input logic [31:0] v,
                                    output logic [1:0] sel,
                                    output logic [31:0] val);
        sel = 2'b00; val = v;
        if (r != 0 && mem_regwrite && mem_writereg == r) begin
            sel = 2'b10; val = mem_aluout;
        end else if (r != 0 && wb_regwrite && wb_writereg == r) begin
            sel = 2'b01; val = wb_result;
        end
    endfunction

    function automatic out_t model_out();
        out_t o;
        logic [31:0] a, b;
        resolve(m.rs, m.rd1, o.fa, a);
        resolve(m.rt, m.rd2, o.fb, b);
        o.srca = m.shiftsrc ? 32'(m.shamt) : a;
        o.srcb = m.alusrc ? m.imm : b;
        o.wdata = b;
        o.alu = m.alu;
        o.valid = m.valid;
        o.regwrite = m.regwrite;
        o.wr = m.wr;
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.srca = srca; o.srcb = srcb; o.wdata = ex_wdata;
        o.alu = alucontrol; o.valid = ex_valid;
        o.regwrite = ex_regwrite; o.wr = ex_writereg;
        o.fa = fwd_a; o.fb = fwd_b;
        return o;
    endfunction

    // Monitor: pops one expectation per presented cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t e, a;
            e = exp_q.pop_front();
            a = dut_out();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d got a=%h b=%h wd=%h alu=%h v=%b rw=%b wr=%0d fa=%b fb=%b want a=%h b=%h wd=%h alu=%h v=%b rw=%b wr=%0d fa=%b fb=%b",
                    vectors, a.srca, a.srcb, a.wdata, a.alu, a.valid,
                    a.regwrite, a.wr, a.fa, a.fb, e.srca, e.srcb, e.wdata,
                    e.alu, e.valid, e.regwrite, e.wr, e.fa, e.fb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        mem_regwrite = p_mem_rw; mem_writereg = p_mem_wr;
        mem_aluout = p_mem_val;
        wb_regwrite = p_wb_rw; wb_writereg = p_wb_wr;
        wb_result = p_wb_val;
        #0;
        exp_q.push_back(model_out());
    endtask

    task automatic rand_id();
        id_valid = 1'($urandom); id_regwrite = 1'($urandom);
        id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        id_shamt = 5'($urandom); id_alucontrol = 4'($urandom);
        id_alusrc = 1'($urandom); id_shiftsrc = 1'($urandom);
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_writereg = 5'($urandom_range(0, 31));
    endtask

    task automatic rand_fwd();
        p_mem_rw = 1'($urandom); p_mem_wr = 5'($urandom_range(0, 3));
        p_mem_val = $urandom;
        p_wb_rw = 1'($urandom); p_wb_wr = 5'($urandom_range(0, 3));
        p_wb_val = $urandom;
    endtask

    task automatic no_fwd();
        p_mem_rw = 0; p_mem_wr = 0; p_mem_val = 0;
        p_wb_rw = 0; p_wb_wr = 0; p_wb_val = 0;
    endtask

    task automatic plain_id();
        id_valid = 1; id_regwrite = 1; id_alusrc = 0; id_shiftsrc = 0;
        id_alucontrol = 4'b0010; id_shamt = 0; id_imm = 0;
        id_writereg = 5'd9;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        id_valid = 0; id_regwrite = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        id_shamt = 0; id_alucontrol = 0; id_alusrc = 0; id_shiftsrc = 0;
        id_rs = 0; id_rt = 0; id_writereg = 0;
        mem_regwrite = 0; mem_writereg = 0; mem_aluout = 0;
        wb_regwrite = 0; wb_writereg = 0; wb_result = 0;
        no_fwd();
        m = bubble();
        #12 rst_n = 1;

        // reset state
        tick();

        // plain operands, no hazards
        plain_id(); id_rd1 = 5; id_rd2 = 7; id_rs = 1; id_rt = 2;
        tick();

        // MEM beats WB on both operands
        id_rs = 3; id_rt = 3; id_rd1 = 32'h11; id_rd2 = 32'h22;
        p_mem_rw = 1; p_mem_wr = 3; p_mem_val = 32'hAA;
        p_wb_rw = 1; p_wb_wr = 3; p_wb_val = 32'hBB;
        tick();

        // WB only
        p_mem_rw = 0;
        tick();

        // register 0 never forwarded
        id_rs = 0; id_rt = 0; id_rd1 = 32'h66; id_rd2 = 32'h77;
        p_mem_rw = 1; p_mem_wr = 0; p_mem_val = 32'h55;
        p_wb_rw = 1; p_wb_wr = 0; p_wb_val = 32'h44;
        tick();

        // shift with immediate; store data still forwarded
        id_shiftsrc = 1; id_shamt = 4; id_alusrc = 1;
        id_imm = 32'hFFFF_FFF0; id_alucontrol = 4'b1011;
        id_rs = 1; id_rt = 2; id_rd2 = 32'h99;
        p_mem_rw = 1; p_mem_wr = 2; p_mem_val = 32'h1234;
        p_wb_rw = 0;
        tick();

        // stall holds for three cycles while forwarding changes
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id(); rand_fwd();
            tick();
        end
        // flush wins over stall
        flush = 1; rand_id(); rand_fwd();
        tick();
        stall = 0; flush = 0;

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            rand_id(); rand_fwd();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
        end
        stall = 0; flush = 0;
        plain_id(); id_rs = 2; id_rt = 3; rand_fwd();
        tick();

        // asynchronous reset away from any clock edge
        #5 rst_n = 0;
        #1;
        vectors++;
        if (dut_out() !== '0) begin
            miscompares++;
            $display("FAIL async_reset got %h want 0", dut_out());
        end
        m = bubble();
        #1 rst_n = 1;
        tick();
        rand_id(); rand_fwd();
        tick();
        tick();

        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
